msk_and_hpc3_stream: RTL
========================

# msk_and_hpc3_stream

Streaming, W-lane, d-share masked AND gadget built on the HPC3 construction, with valid/ready flow control on the operand, randomness and result channels. Each accepted transfer consumes one fresh randomness word and produces the masked product one cycle later. Output backpressure holds the result stable. The block sits between masked datapath stages, such as S-box layers, where operands and randomness arrive irregularly.

## Interface
Parameters:
- d, `DEFAULTSHARES (2): number of shares, d ≥ 2
- W, 8: number of independent bit lanes
- RPL, d*(d-1): random bits per lane (derived, localparam)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands ina/inb are valid
- in_ready  out  1  block accepts operands this cycle
- ina  in  d*W  sharing of a; lane l share s at bit s*W+l
- inb  in  d*W  sharing of b; same layout
- rnd_valid  in  1  rnd word is valid
- rnd_ready  out  1  rnd word consumed this cycle
- rnd  in  W*RPL  fresh randomness; lane l uses rnd[l*RPL +: RPL]
- out_valid  out  1  out holds a valid result
- out_ready  in  1  downstream accepts out
- out  out  d*W  sharing of a&b; same layout

## Operation
- fire = in_valid & rnd_valid & in_ready; in_ready = !out_valid | out_ready; rnd_ready = fire.
- An operand is never accepted without randomness; randomness is never consumed without an operand.
- Per lane, the low half of RPL is r0 and the high half is r1. For pair i<j the index is i*d − i(i+1)/2 + (j−1−i), and r[i][j] = r[j][i].
- On fire, the following per-lane, per-share registers load:
  - a_i b_i
  - a_i
  - u_ij = (¬a_i & r0_ij) ^ r1_ij
  - w_ij = b_j ^ r0_ij, for all j≠i
- out_i = reg(a_i b_i) ^ XOR_j≠i [ u_ij ^ (reg(a_i) & w_ij) ], computed combinationally from registers only. No input-to-output combinational path is allowed.
- Unmasked correctness: XOR over s of out = (XOR of ina) & (XOR of inb), per lane.
- All registers load only on fire. Otherwise they hold, except as described under Configuration.
- out_valid: set on fire; cleared when out_ready & !fire; unchanged when !out_ready.
- Simultaneous out_ready and fire: the old result retires and the new one loads. out_valid stays 1, giving full throughput of one transfer per cycle.
- The two randomness-dependent register groups (u, w) must be separate flops; they must not be merged or optimised across shares.

## Timing
- Latency: 1 cycle from fire to out_valid with the result.
- Throughput: 1 per cycle while out_ready is high.
- Reset (rst_n low, asynchronous):
  - all share registers go to 0, out_valid to 0, so out = 0
  - in_ready = 1; rnd_ready = 0 until the next fire
- Reset mid-stream: any pending result is discarded. After rst_n deasserts, the first fire is accepted on the first rising edge.
- Stall: while out_valid & !out_ready, out is bit-stable and in_ready = 0, and no randomness is consumed.
- Whether in_valid or rnd_valid arrives first does not matter; the transfer fires on the cycle both are high.

## Configuration
- MSK_HPC3_IDLE_CLEAR_EN defined: on a cycle with out_valid & out_ready & !fire, all share registers load 0, so out returns to 0 whenever out_valid = 0. This prevents stale shares from lingering on the bus.
- Not defined: registers hold their last value. out is stale but stable while out_valid = 0.
- In both cases, behaviour while out_valid = 1 is identical.

## Test plan
- d=2, W=1, ina=(1,0), inb=(0,1), rnd=r0=1,r1=0, all valids high, out_ready=1 → next cycle out_valid=1, out=(0,1), XOR=1.
- d=3, W=8, 1000 random transfers with random operands, random rnd and random valid/ready gaps → every result has XOR(out)=XOR(ina)&XOR(inb). Results arrive in order; rnd_ready pulses equal the number of results.
- out_ready=0 for 5 cycles after a result → out stable, in_ready=0, rnd_ready=0, no new fire. Raise out_ready with in_valid & rnd_valid high → back-to-back transfer in the same cycle.
- in_valid=1 with rnd_valid=0 for 3 cycles → no fire, out_valid unchanged. rnd_valid rises → fire, result 1 cycle later.
- Assert rst_n=0 asynchronously mid-cycle while out_valid=1 → out_valid=0 and out=0 immediately. Deassert → first transfer accepted normally.
- With MSK_HPC3_IDLE_CLEAR_EN: retire a result with no new fire → out=0 next cycle. Without the macro → out keeps the previous shares.

Source files
------------

// File: rtl/msk_and_hpc3_stream.sv
// Streaming W-lane, d-share HPC3 masked AND with valid/ready on operands, randomness and result.
// Optional MSK_HPC3_IDLE_CLEAR_EN zeroes the share registers when a result retires with no new transfer.

`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_and_hpc3_stream #(
    parameter int d = `DEFAULTSHARES,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [d*W-1:0]         ina,
    input  logic [d*W-1:0]         inb,
    input  logic                   rnd_valid,
    output logic                   rnd_ready,
    input  logic [W*d*(d-1)-1:0]   rnd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [d*W-1:0]         out
);

    localparam int RPL  = d * (d - 1);
    localparam int HALF = RPL / 2;

    logic fire;
    logic idle_clear;
    logic out_valid_reg;

    assign in_ready  = !out_valid_reg || out_ready;
    assign fire      = in_valid && rnd_valid && in_ready;
    assign rnd_ready = fire;
    assign out_valid = out_valid_reg;

`ifdef MSK_HPC3_IDLE_CLEAR_EN
    assign idle_clear = out_valid_reg && out_ready && !fire;
`else
    assign idle_clear = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
        end else if (fire) begin
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    genvar gi, gj, gl;

    for (gi = 0; gi < d; gi++) begin : g_share
        logic [W-1:0] a_in;
        logic [W-1:0] b_in;
        logic [W-1:0] ab_reg;
        logic [W-1:0] a_reg;
        logic [W-1:0] share_out;
        logic [W-1:0] term [d];

        assign a_in = ina[gi*W +: W];
        assign b_in = inb[gi*W +: W];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ab_reg <= '0;
                a_reg  <= '0;
            end else if (fire) begin
                ab_reg <= a_in & b_in;
                a_reg  <= a_in;
            end else if (idle_clear) begin
                ab_reg <= '0;
                a_reg  <= '0;
            end
        end

        for (gj = 0; gj < d; gj++) begin : g_pair
            if (gj != gi) begin : g_cross
                // r[i][j] and r[j][i] share one bit: index by the ordered pair (lo, hi).
                localparam int LO  = (gi < gj) ? gi : gj;
                localparam int HI  = (gi < gj) ? gj : gi;
                localparam int IDX = LO * d - (LO * (LO + 1)) / 2 + (HI - 1 - LO);

                logic [W-1:0] r0;
                logic [W-1:0] r1;
                logic [W-1:0] b_other;
                logic [W-1:0] u_next;
                logic [W-1:0] w_next;
                logic [W-1:0] u_reg;
                logic [W-1:0] w_reg;

                for (gl = 0; gl < W; gl++) begin : g_lane
                    assign r0[gl] = rnd[gl*RPL + IDX];
                    assign r1[gl] = rnd[gl*RPL + HALF + IDX];
                end

                assign b_other = inb[gj*W +: W];
                assign u_next  = (~a_in & r0) ^ r1;
                assign w_next  = b_other ^ r0;

                // u and w stay as distinct flops per share pair so no glitch can
                // combine a randomness-free operand with its own mask.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        u_reg <= '0;
                        w_reg <= '0;
                    end else if (fire) begin
                        u_reg <= u_next;
                        w_reg <= w_next;
                    end else if (idle_clear) begin
                        u_reg <= '0;
                        w_reg <= '0;
                    end
                end

                assign term[gj] = u_reg ^ (a_reg & w_reg);
            end else begin : g_self
                assign term[gj] = '0;
            end
        end

        always_comb begin
            share_out = ab_reg;
            for (int j = 0; j < d; j++) begin
                share_out = share_out ^ term[j];
            end
        end

        assign out[gi*W +: W] = share_out;
    end

endmodule
